// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of uart_tx_fifo: the core pushes bytes and reads back FIFO status.
interface uart_tx_fifo_if #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  // Handshake: a byte on uart_dat_i is taken on the rising edge where
  // uart_wr_i=1 and uart_full_o=0. There is no back-pressure beyond that:
  // a write seen while full is discarded and latches uart_ovf_o until cleared.
  logic                 uart_wr_i;
  logic [DATA_BITS-1:0] uart_dat_i;
  logic                 uart_ovf_clr_i;
  logic                 uart_full_o;
  logic [LW-1:0]        uart_level_o;
  logic                 uart_busy_o;
  logic                 uart_ovf_o;

  modport master (
    output uart_wr_i, uart_dat_i, uart_ovf_clr_i,
    input  uart_full_o, uart_level_o, uart_busy_o, uart_ovf_o
  );

  modport slave (
    input  uart_wr_i, uart_dat_i, uart_ovf_clr_i,
    output uart_full_o, uart_level_o, uart_busy_o, uart_ovf_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a TX FIFO, with a fractional (accumulator) baud generator.
// Frames are chained back-to-back; uart_state_o exposes the FSM (0 = idle).
module uart_tx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          sys_clk_i,
  input  logic          sys_rstn_i,
  uart_tx_fifo_if.slave bus,
  output logic          uart_tx,
  output logic [2:0]    uart_state_o
);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int ACC_W = $clog2(CLK_HZ + BAUD) + 1;
  localparam int BCW   = $clog2(DATA_BITS);

  localparam logic [ACC_W-1:0] BAUD_INC = ACC_W'(BAUD);
  localparam logic [ACC_W-1:0] CLK_MOD  = ACC_W'(CLK_HZ);
  localparam logic [BCW-1:0]   LAST_BIT = BCW'(DATA_BITS - 1);
  localparam logic [LW-1:0]    DEPTH_LV = LW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // ---------------- FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        level;
  logic [LW-1:0]        level_nxt;
  logic                 full;
  logic                 ovf;
  logic                 push;
  logic                 pop;
  logic [DATA_BITS-1:0] head;

  assign push = bus.uart_wr_i & ~full;
  assign head = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    case ({push, pop})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  always_ff @(posedge sys_clk_i) begin
    if (push) mem[wr_ptr] <= bus.uart_dat_i;
  end

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level_nxt;
      full  <= (level_nxt == DEPTH_LV);
      // A dropped write outranks a same-cycle clear so no overflow goes unseen.
      if (bus.uart_wr_i && full)     ovf <= 1'b1;
      else if (bus.uart_ovf_clr_i)   ovf <= 1'b0;
    end
  end

  // ---------------- Baud generator + FSM ----------------
  state_e               state;
  state_e               state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nxt;
  logic [ACC_W-1:0]     acc_sum;
  logic                 tick;
  logic [DATA_BITS-1:0] sh;
  logic [DATA_BITS-1:0] sh_nxt;
  logic [BCW-1:0]       bit_cnt;
  logic [BCW-1:0]       bit_cnt_nxt;
  logic                 stop_cnt;
  logic                 stop_cnt_nxt;
  logic                 par;
  logic                 par_nxt;
  logic                 tx;
  logic                 tx_nxt;
  logic                 load;

  assign acc_sum = acc + BAUD_INC;
  assign tick    = (state != S_IDLE) && (acc_sum >= CLK_MOD);

  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state    <= S_IDLE;
      acc      <= '0;
      sh       <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par      <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_nxt;
      acc      <= acc_nxt;
      sh       <= sh_nxt;
      bit_cnt  <= bit_cnt_nxt;
      stop_cnt <= stop_cnt_nxt;
      par      <= par_nxt;
      tx       <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    acc_nxt      = acc;
    sh_nxt       = sh;
    bit_cnt_nxt  = bit_cnt;
    stop_cnt_nxt = stop_cnt;
    par_nxt      = par;
    tx_nxt       = tx;
    load         = 1'b0;
    pop          = 1'b0;

    if (state != S_IDLE) acc_nxt = tick ? (acc_sum - CLK_MOD) : acc_sum;

    case (state)
      S_IDLE: begin
        if (level != '0) begin
          load    = 1'b1;
          acc_nxt = '0;
        end
      end
      S_START: begin
        if (tick) begin
          tx_nxt      = sh[0];
          sh_nxt      = sh >> 1;
          bit_cnt_nxt = '0;
          state_nxt   = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            if (PARITY != 0) begin
              tx_nxt    = par;
              state_nxt = S_PARITY;
            end else begin
              tx_nxt       = 1'b1;
              stop_cnt_nxt = 1'b0;
              state_nxt    = S_STOP;
            end
          end else begin
            tx_nxt      = sh[0];
            sh_nxt      = sh >> 1;
            bit_cnt_nxt = bit_cnt + BCW'(1);
          end
        end
      end
      S_PARITY: begin
        if (tick) begin
          tx_nxt       = 1'b1;
          stop_cnt_nxt = 1'b0;
          state_nxt    = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (stop_cnt == 1'(STOP_BITS - 1)) begin
            // Chain the next frame without an idle gap; the accumulator keeps
            // its fractional remainder so the long-run rate stays exact.
            if (level != '0) load = 1'b1;
            else             state_nxt = S_IDLE;
          end else begin
            stop_cnt_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (load) begin
      pop       = 1'b1;
      sh_nxt    = head;
      par_nxt   = (PARITY == 2) ? ^head : ~^head;
      tx_nxt    = 1'b0;
      state_nxt = S_START;
    end
  end

  assign uart_tx          = tx;
  assign uart_state_o     = state;
  assign bus.uart_full_o  = full;
  assign bus.uart_level_o = level;
  assign bus.uart_ovf_o   = ovf;
  assign bus.uart_busy_o  = (state != S_IDLE) || (level != '0);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: four configurations checked every cycle against a
// frame/queue model, plus hand-computed timing and bit expectations.
module tb_uart_tx_fifo;
  localparam int N = 4;
  // u0: 16 Hz/1 baud 8N1 depth 4, u1: 8E1, u2: 7O2, u3: defaults (100 MHz/115200 8N1 depth 16)
  localparam longint CLKS  [N] = '{16, 16, 16, 100000000};
  localparam longint BAUDS [N] = '{1, 1, 1, 115200};
  localparam int     NBS   [N] = '{8, 8, 7, 8};
  localparam int     PARS  [N] = '{0, 2, 1, 0};
  localparam int     SBS   [N] = '{1, 1, 2, 1};
  localparam int     DEPS  [N] = '{4, 4, 4, 16};

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  logic       wr_d  [N];
  logic [7:0] dat_d [N];
  logic       clr_d [N];

  logic [N-1:0] tx_v, full_v, busy_v, ovf_v;
  logic [31:0]  lvl_a [N];
  logic [2:0]   st0, st1, st2, st3;
  logic [2:0]   st_a [N];

  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if0 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(4))  if1 ();
  uart_tx_fifo_if #(.DATA_BITS(7), .FIFO_DEPTH(4))  if2 ();
  uart_tx_fifo_if #(.DATA_BITS(8), .FIFO_DEPTH(16)) if3 ();

  assign if0.uart_wr_i = wr_d[0]; assign if0.uart_dat_i = dat_d[0];      assign if0.uart_ovf_clr_i = clr_d[0];
  assign if1.uart_wr_i = wr_d[1]; assign if1.uart_dat_i = dat_d[1];      assign if1.uart_ovf_clr_i = clr_d[1];
  assign if2.uart_wr_i = wr_d[2]; assign if2.uart_dat_i = dat_d[2][6:0]; assign if2.uart_ovf_clr_i = clr_d[2];
  assign if3.uart_wr_i = wr_d[3]; assign if3.uart_dat_i = dat_d[3];      assign if3.uart_ovf_clr_i = clr_d[3];

  assign full_v = {if3.uart_full_o, if2.uart_full_o, if1.uart_full_o, if0.uart_full_o};
  assign busy_v = {if3.uart_busy_o, if2.uart_busy_o, if1.uart_busy_o, if0.uart_busy_o};
  assign ovf_v  = {if3.uart_ovf_o,  if2.uart_ovf_o,  if1.uart_ovf_o,  if0.uart_ovf_o};
  assign lvl_a[0] = 32'(if0.uart_level_o);
  assign lvl_a[1] = 32'(if1.uart_level_o);
  assign lvl_a[2] = 32'(if2.uart_level_o);
  assign lvl_a[3] = 32'(if3.uart_level_o);
  assign st_a[0] = st0; assign st_a[1] = st1; assign st_a[2] = st2; assign st_a[3] = st3;

  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)) u0 (
    .sys_clk_i(clk), .sys_rstn_i(rstn), .bus(if0.slave), .uart_tx(tx_v[0]), .uart_state_o(st0));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)) u1 (
    .sys_clk_i(clk), .sys_rstn_i(rstn), .bus(if1.slave), .uart_tx(tx_v[1]), .uart_state_o(st1));
  uart_tx_fifo #(.CLK_HZ(16), .BAUD(1), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(4)) u2 (
    .sys_clk_i(clk), .sys_rstn_i(rstn), .bus(if2.slave), .uart_tx(tx_v[2]), .uart_state_o(st2));
  uart_tx_fifo #(.CLK_HZ(100000000), .BAUD(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u3 (
    .sys_clk_i(clk), .sys_rstn_i(rstn), .bus(if3.slave), .uart_tx(tx_v[3]), .uart_state_o(st3));

  // ---------------- scoreboard / model ----------------
  int          n_total = 0;
  int          n_bad   = 0;
  longint      cyc     = 0;
  bit          chk_en  = 1'b0;
  logic [7:0]  exp_q [N][$];
  bit          act   [N];
  longint      s0    [N];
  longint      nb    [N];
  longint      bidx  [N];
  longint      fbase [N];
  int          fl    [N];
  bit          fb    [N][16];
  bit          m_ovf [N];

  function automatic longint ceil_div(longint a, longint b);
    return (a + b - 1) / b;
  endfunction

  task automatic cmp(input int i, input string what, input logic [31:0] a, input logic [31:0] e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL u%0d.%s actual=%0h required=%0h cyc=%0d", i, what, a, e, cyc);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      act[i] = 1'b0;
      m_ovf[i] = 1'b0;
      bidx[i] = 0; fbase[i] = 0; fl[i] = 0; s0[i] = 0; nb[i] = 0;
    end
  endtask

  // A frame is a plain bit list: start, data LSB first, optional parity, stops.
  task automatic load_frame(input int i, input logic [7:0] d);
    int  k;
    bit  p;
    k = 0; p = 1'b0;
    fb[i][k] = 1'b0; k++;
    for (int b = 0; b < NBS[i]; b++) begin
      fb[i][k] = d[b]; p = p ^ d[b]; k++;
    end
    if (PARS[i] == 2) begin fb[i][k] = p;  k++; end
    if (PARS[i] == 1) begin fb[i][k] = ~p; k++; end
    for (int s = 0; s < SBS[i]; s++) begin fb[i][k] = 1'b1; k++; end
    fl[i] = k;
  endtask

  // Bit j of a back-to-back chain begins ceil(j*CLK/BAUD) cycles after the chain starts.
  task automatic model_edge(input int i);
    int pre;
    pre = exp_q[i].size();
    if (act[i]) begin
      if (cyc == nb[i]) begin
        bidx[i]++;
        nb[i] = s0[i] + ceil_div((bidx[i] + 1) * CLKS[i], BAUDS[i]);
        if (bidx[i] == fbase[i] + longint'(fl[i])) begin
          if (pre > 0) begin
            load_frame(i, exp_q[i].pop_front());
            fbase[i] = bidx[i];
          end else begin
            act[i] = 1'b0;
          end
        end
      end
    end else if (pre > 0) begin
      act[i] = 1'b1; s0[i] = cyc; bidx[i] = 0; fbase[i] = 0;
      nb[i] = cyc + ceil_div(CLKS[i], BAUDS[i]);
      load_frame(i, exp_q[i].pop_front());
    end
    if (wr_d[i] && pre >= DEPS[i]) m_ovf[i] = 1'b1;
    else if (clr_d[i])            m_ovf[i] = 1'b0;
    if (wr_d[i] && pre < DEPS[i])  exp_q[i].push_back(dat_d[i] & 8'((1 << NBS[i]) - 1));
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk);
      cyc++;
      if (rstn) for (int i = 0; i < N; i++) model_edge(i);
    end
  end

  always @(negedge rstn) model_clear();

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        for (int i = 0; i < N; i++) begin
          cmp(i, "tx",    32'(tx_v[i]),   act[i] ? 32'(fb[i][bidx[i] - fbase[i]]) : 32'd1);
          cmp(i, "level", lvl_a[i],       32'(exp_q[i].size()));
          cmp(i, "full",  32'(full_v[i]), 32'(exp_q[i].size() == DEPS[i]));
          cmp(i, "busy",  32'(busy_v[i]), 32'(act[i] || exp_q[i].size() > 0));
          cmp(i, "ovf",   32'(ovf_v[i]),  32'(m_ovf[i]));
          cmp(i, "idle",  32'(st_a[i] == 3'd0), 32'(!act[i]));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push(input int i, input logic [7:0] d);
    @(negedge clk);
    wr_d[i] = 1'b1;
    dat_d[i] = d;
  endtask

  task automatic release_wr(input int i);
    @(negedge clk);
    wr_d[i] = 1'b0;
  endtask

  task automatic wait_cyc(input longint c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_val(input int i, input bit is_tx, input logic v, input int bound, output longint at);
    at = -1;
    for (int n = 0; n < bound; n++) begin
      if ((is_tx ? tx_v[i] : busy_v[i]) === v) begin
        at = cyc;
        return;
      end
      @(negedge clk);
    end
    n_total++;
    n_bad++;
    $display("FAIL timeout u%0d.%s never reached %0b", i, is_tx ? "tx" : "busy", v);
  endtask

  // ---------------- directed tests ----------------
  longint     tf, te, th, tb, t_w0;
  logic [9:0]  e0;
  logic [10:0] e1, e2;

  initial begin
    for (int i = 0; i < N; i++) begin
      wr_d[i] = 1'b0; dat_d[i] = 8'h00; clr_d[i] = 1'b0;
    end
    #1 rstn = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      cmp(i, "rst.tx",    32'(tx_v[i]),   32'd1);
      cmp(i, "rst.level", lvl_a[i],       32'd0);
      cmp(i, "rst.busy",  32'(busy_v[i]), 32'd0);
      cmp(i, "rst.ovf",   32'(ovf_v[i]),  32'd0);
    end
    #2 rstn = 1'b1;
    @(negedge clk);

    // 8N1 0x55: 10 bits of 16 cycles each, 160-cycle frame.
    e0 = 10'b1010101010;
    push(0, 8'h55);
    release_wr(0);
    wait_val(0, 1'b1, 1'b0, 40, tf);
    for (int k = 0; k < 10; k++) begin
      wait_cyc(tf + 8 + 16 * k);
      cmp(0, "t1.bit", 32'(tx_v[0]), 32'(e0[k]));
    end
    wait_val(0, 1'b0, 1'b0, 400, te);
    cmp(0, "t1.frame", 32'(te - tf), 32'd160);

    // 8E1 0x07 (parity 1) and 7O2 0x00 (parity 1, two stops), both 176 cycles.
    e1 = 11'b11000001110;
    e2 = 11'b11100000000;
    @(negedge clk);
    wr_d[1] = 1'b1; dat_d[1] = 8'h07;
    wr_d[2] = 1'b1; dat_d[2] = 8'h00;
    @(negedge clk);
    wr_d[1] = 1'b0; wr_d[2] = 1'b0;
    wait_val(1, 1'b1, 1'b0, 40, tf);
    for (int k = 0; k < 11; k++) begin
      wait_cyc(tf + 8 + 16 * k);
      cmp(1, "t2.bit", 32'(tx_v[1]), 32'(e1[k]));
      cmp(2, "t2.bit", 32'(tx_v[2]), 32'(e2[k]));
    end
    wait_val(1, 1'b0, 1'b0, 400, te);
    cmp(1, "t2.frame", 32'(te - tf), 32'd176);
    wait_val(2, 1'b0, 1'b0, 400, tb);
    cmp(2, "t2.frame", 32'(tb - tf), 32'd176);

    // Depth 4: six back-to-back writes, the sixth is dropped, five chained frames.
    push(0, 8'h41);
    t_w0 = cyc + 1;
    for (int k = 1; k < 6; k++) push(0, 8'h41 + 8'(k));
    release_wr(0);
    cmp(0, "t3.full",  32'(full_v[0]), 32'd1);
    cmp(0, "t3.ovf",   32'(ovf_v[0]),  32'd1);
    cmp(0, "t3.level", lvl_a[0],       32'd4);
    @(negedge clk); clr_d[0] = 1'b1;
    @(negedge clk); clr_d[0] = 1'b0;
    cmp(0, "t3.ovfclr", 32'(ovf_v[0]), 32'd0);
    wait_val(0, 1'b0, 1'b0, 1000, te);
    cmp(0, "t3.chain", 32'(te - (t_w0 + 1)), 32'd800);

    // Reset in the middle of data bit 3 with a full FIFO and ovf set.
    push(0, 8'h11);
    t_w0 = cyc + 1;
    for (int k = 1; k < 6; k++) push(0, 8'h11 + 8'(k));
    release_wr(0);
    wait_cyc(t_w0 + 1 + 16 + 48 + 8);
    cmp(0, "t4.preovf", 32'(ovf_v[0]), 32'd1);
    cmp(0, "t4.pretx",  32'(tx_v[0]),  32'd0);
    #2 rstn = 1'b0;
    #1;
    cmp(0, "t4.tx",    32'(tx_v[0]),   32'd1);
    cmp(0, "t4.level", lvl_a[0],       32'd0);
    cmp(0, "t4.busy",  32'(busy_v[0]), 32'd0);
    cmp(0, "t4.ovf",   32'(ovf_v[0]),  32'd0);
    cmp(0, "t4.full",  32'(full_v[0]), 32'd0);
    repeat (2) @(negedge clk);
    #2 rstn = 1'b1;
    repeat (200) @(negedge clk);
    cmp(0, "t4.after.busy", 32'(busy_v[0]), 32'd0);
    cmp(0, "t4.after.tx",   32'(tx_v[0]),   32'd1);

    // Write on the pop edge with level 3: accepted, level unchanged.
    push(0, 8'h21);
    t_w0 = cyc + 1;
    for (int k = 1; k < 4; k++) push(0, 8'h21 + 8'(k));
    release_wr(0);
    cmp(0, "t6.level0", lvl_a[0], 32'd3);
    wait_cyc(t_w0 + 1 + 159);
    wr_d[0] = 1'b1; dat_d[0] = 8'h3C;
    release_wr(0);
    cmp(0, "t6.level", lvl_a[0],   32'd3);
    cmp(0, "t6.ovf",   32'(ovf_v[0]), 32'd0);
    wait_val(0, 1'b0, 1'b0, 1200, te);
    cmp(0, "t6.chain", 32'(te - (t_w0 + 1)), 32'd800);

    // Default rates: six 0xA5 frames chained.
    push(3, 8'hA5);
    t_w0 = cyc + 1;
    for (int k = 1; k < 6; k++) push(3, 8'hA5);
    release_wr(3);
    tf = t_w0 + 1;
    wait_val(3, 1'b1, 1'b1, 2000, th);
    cmp(3, "t5.start", 32'(th - tf), 32'd869);
    wait_cyc(tf + 8680);
    cmp(3, "t5.stop", 32'(tx_v[3]), 32'd1);
    wait_cyc(tf + 8681);
    cmp(3, "t5.start2", 32'(tx_v[3]), 32'd0);
    wait_val(3, 1'b0, 1'b0, 60000, te);
    cmp(3, "t5.chain", 32'(te - tf), 32'd52084);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #950000;
    n_bad++;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog");
  end
endmodule
